// File: rtl/sc_spi_spt_if.sv
// rtl/sc_spi_spt_if.sv - SPI pin bundle for sc_spi_spt; MISOOE exists only with SC_SPI_SPT_MISOOE_EN
interface sc_spi_spt_if;
  logic CSB;
  logic SCLK;
  logic MOSI;
  logic MISO;
`ifdef SC_SPI_SPT_MISOOE_EN
  logic MISOOE;
  modport master (output CSB, SCLK, MOSI, input MISO, MISOOE);
  modport slave  (input CSB, SCLK, MOSI, output MISO, MISOOE);
`else
  modport master (output CSB, SCLK, MOSI, input MISO);
  modport slave  (input CSB, SCLK, MOSI, output MISO);
`endif
endinterface

// File: rtl/sc_spi_spt.sv
// rtl/sc_spi_spt.sv - SPI protocol target: oversampled CSB/SCLK/MOSI, word-buffered RX/TX
// Optional MISOOE output enabled by defining SC_SPI_SPT_MISOOE_EN.
module sc_spi_spt #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic [8:0]  DWIDTH,
  input  logic [31:0] TXDATA,
  output logic [3:0]  TXDPT,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic [3:0]  RXDPT,
  output logic        FRAMEDONE,
  output logic        FRAMEERR,
  output logic        SELECTED,
  sc_spi_spt_if.slave spi
);

  typedef enum logic [1:0] {IDLE, SEL, SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync;
  logic        csb_s, sclk_s, mosi_s;
  logic        csb_d, sclk_d;
  logic        csb_fall, csb_rise, sample_e, launch_e;
  logic [8:0]  rc, tc;
  logic [8:0]  rx_pos, tx_pos;
  logic [31:0] rxshift;
  logic        rx_last, rx_emit;
  logic        ld_pend, miso_q;
  logic        do_clr, do_sample, do_adv, do_load, do_err;

  // Returns {word[3:0], bit[4:0]}; a short final byte is right-aligned, MSB first.
  function automatic logic [8:0] bitpos(input logic [8:0] fc, input logic [8:0] dw, input logic bo);
    logic [2:0] lo;
    if (!bo) return dw - fc;
    lo = (fc[8:3] == dw[8:3]) ? (dw[2:0] - fc[2:0]) : ~fc[2:0];
    return {fc[8:3], lo};
  endfunction

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      csb_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      csb_d     <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi.CSB};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      csb_d     <= csb_s;
      sclk_d    <= sclk_s;
    end
  end

  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csb_fall = csb_d & ~csb_s;
  assign csb_rise = csb_s & ~csb_d;
  assign sample_e = (CPOL ^ CPHA) ? (sclk_d & ~sclk_s) : (sclk_s & ~sclk_d);
  assign launch_e = (CPOL ^ CPHA) ? (sclk_s & ~sclk_d) : (sclk_d & ~sclk_s);

  assign rx_pos  = bitpos(rc, DWIDTH, BORDER);
  assign tx_pos  = bitpos(tc, DWIDTH, BORDER);
  assign rx_last = (rc == DWIDTH);
  assign rx_emit = (BORDER ? (rx_pos[4:0] == 5'd24) : (rx_pos[4:0] == 5'd0)) | rx_last;

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_clr    = 1'b0;
    do_sample = 1'b0;
    do_adv    = 1'b0;
    do_load   = 1'b0;
    do_err    = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall) begin
          state_nxt = SEL;
          do_clr    = 1'b1;
          do_load   = ~CPHA;
        end
      end
      default: begin
        if (sample_e) begin
          do_sample = 1'b1;
          state_nxt = rx_last ? SEL : SHIFT;
          do_load   = rx_last & ~CPHA;
        end
        // In SEL a CPHA=0 launch is the trailing edge of the previous frame.
        if (launch_e) begin
          if (state == SHIFT) begin
            do_adv  = (tc != DWIDTH);
            do_load = do_adv;
          end else begin
            do_load = CPHA;
          end
        end
        if (csb_rise) begin
          do_err    = (state_nxt == SHIFT);
          state_nxt = IDLE;
          do_load   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      rc        <= '0;
      tc        <= '0;
      rxshift   <= '0;
      ld_pend   <= 1'b0;
      miso_q    <= 1'b0;
      RXVALID   <= 1'b0;
      RXDPT     <= '0;
      FRAMEDONE <= 1'b0;
      FRAMEERR  <= 1'b0;
    end else begin
      RXVALID   <= do_sample & rx_emit;
      FRAMEDONE <= do_sample & rx_last;
      FRAMEERR  <= do_err;
      ld_pend   <= do_load;
      if (do_clr) begin
        rc <= '0;
        tc <= '0;
      end
      if (do_adv) tc <= tc + 9'd1;
      if (do_sample) begin
        rxshift[rx_pos[4:0]] <= mosi_s;
        RXDPT                <= rx_pos[8:5];
        if (rx_last) begin
          rc <= '0;
          tc <= '0;
        end else begin
          rc <= rc + 9'd1;
        end
      end
      if (ld_pend) miso_q <= TXDATA[tx_pos[4:0]];
      if (state_nxt == IDLE) miso_q <= 1'b0;
    end
  end

`ifdef SC_SPI_SPT_MISOOE_EN
  logic misooe_q;

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      misooe_q <= 1'b0;
    end else begin
      if (ld_pend) misooe_q <= 1'b1;
      if (state_nxt == IDLE) misooe_q <= 1'b0;
    end
  end

  assign spi.MISOOE = misooe_q;
`endif

  assign spi.MISO = miso_q;
  assign TXDPT    = tx_pos[8:5];
  assign RXDATA   = rxshift;
  assign SELECTED = (state != IDLE);

endmodule
